// File: rtl/arb_pkg.sv
// Shared types and master ids for the two-master memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;

  localparam logic ARB_IFU = 1'b0;
  localparam logic ARB_LSU = 1'b1;

endpackage

// File: rtl/arb_grant.sv
// Combinational tie-break between IFU and LSU requests.
// ARB_ROUND_ROBIN_EN selects alternating ties; otherwise LSU wins every tie.
module arb_grant
  import arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant
);

  always_comb begin
    grant = ARB_IFU;
    if (ifu_valid && lsu_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_grant == ARB_IFU) ? ARB_LSU : ARB_IFU;
`else
      grant = ARB_LSU;
`endif
    end else if (lsu_valid) begin
      grant = ARB_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IFU and LSU requests onto one memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break instead of LSU priority.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MaskW = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  arb_grant u_grant (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_q),
`endif
    .grant      (grant)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    mem_req_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          owner_d = grant;
          state_d = REQ;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = grant;
`endif
          if (grant == ARB_LSU) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_addr;
            wen_d         = lsu_wen;
            wdata_d       = lsu_wdata;
            wmask_d       = lsu_wmask;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wmask_d       = '0;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        // Stores complete with zero data so the LSU never sees stale read data.
        if (mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q == ARB_LSU) begin
          lsu_rsp_valid = 1'b1;
          lsu_rdata     = rdata_q;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rdata     = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= ARB_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= ARB_IFU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, memory model and response scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rdy;
    int          rsp;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  logic grant_log[$];

  bit          busy = 0;
  bit          due = 0;
  bit          spur = 0;
  bit          req_seen = 0;
  int          acc_cnt = 0, pulse_cnt = 0, acc_cyc = 0, pulse_cyc = 0, req_due = 0;
  int          rdy_dly = 0, rsp_dly = 1, rdy_cnt = 0, rsp_cnt = 0;
  logic [31:0] mem_data = '0, exp_data = '0;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: sample DUT, score, drive memory side, advance to next negedge.
  task automatic step();
    req_t q;
    rsp_t r;
    logic g;
    #1;
    if (!busy && (ifu_req_valid || lsu_req_valid)) begin
      chk("ready_onehot", (ifu_req_ready ^ lsu_req_ready) &&
          ((ifu_req_ready && ifu_req_valid) || (lsu_req_ready && lsu_req_valid)), 1);
      g = lsu_req_ready;
      if (g) begin
        q = '{owner: 1'b1, addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
      end else begin
        q = '{owner: 1'b0, addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
      end
      exp_req_q.push_back(q);
      exp_rsp_q.push_back('{owner: g, data: exp_data});
      grant_log.push_back(g);
      busy     = 1;
      acc_cnt++;
      acc_cyc  = cyc;
      req_due  = cyc + 1;
      req_seen = 0;
      rdy_cnt  = rdy_dly;
    end else begin
      chk("ready_idle", {ifu_req_ready, lsu_req_ready}, 0);
    end

    if (due && exp_rsp_q.size() > 0) begin
      r = exp_rsp_q.pop_front();
      chk("rsp_ifu_valid", ifu_rsp_valid, r.owner == 1'b0);
      chk("rsp_lsu_valid", lsu_rsp_valid, r.owner == 1'b1);
      chk("rsp_data", r.owner ? lsu_rdata : ifu_rdata, r.data);
      due  = 0;
      busy = 0;
      pulse_cnt++;
      pulse_cyc = cyc;
    end else begin
      chk("no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    end

    mem_rsp_valid = 1'b0;
    mem_rdata     = $urandom();
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = mem_data;
        due           = 1;
      end
    end else if (spur) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'h1234_5678;
      spur          = 0;
    end

    mem_req_ready = 1'b0;
    if (mem_req_valid) begin
      if (exp_req_q.size() == 0) begin
        chk("mem_req_unexp", mem_req_valid, 0);
      end else begin
        q = exp_req_q[0];
        if (!req_seen) begin
          chk("mem_req_cycle", cyc, req_due);
          req_seen = 1;
        end
        chk("mem_addr", mem_addr, q.addr);
        chk("mem_wen", mem_wen, q.wen);
        chk("mem_wmask", mem_wmask, q.wmask);
        if (q.wen) chk("mem_wdata", mem_wdata, q.wdata);
        if (rdy_cnt > 0) begin
          rdy_cnt--;
        end else begin
          mem_req_ready = 1'b1;
          void'(exp_req_q.pop_front());
          rsp_cnt = rsp_dly;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_acc(output int n);
    int start;
    start = acc_cnt;
    n = 0;
    forever begin
      step();
      if (acc_cnt != start || n > 20) break;
      n++;
    end
  endtask

  task automatic wait_pulse();
    int start;
    int n;
    start = pulse_cnt;
    n = 0;
    while (pulse_cnt == start && n < 60) begin
      step();
      n++;
    end
    if (pulse_cnt == start) chk("pulse_timeout", pulse_cnt, start + 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    rdy_dly  = v.rdy;
    rsp_dly  = v.rsp;
    mem_data = v.mdata;
    exp_data = v.exp_rdata;
    if (v.lsu) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = v.addr;
      lsu_wen       = v.wen;
      lsu_wdata     = v.wdata;
      lsu_wmask     = v.wmask;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr      = v.addr;
    end
    wait_acc(n);
    chk({tag, "_acc_wait"}, n, 0);
    if (grant_log.size() > 0) chk({tag, "_owner"}, grant_log[grant_log.size()-1], v.lsu);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    wait_pulse();
    chk({tag, "_latency"}, pulse_cyc - acc_cyc, v.exp_lat);
  endtask

  initial begin
    int   n;
    int   base;
    logic exp_tie[4];

    vecs[0] = '{0, 32'h8000_0000, 0, 32'h0, 4'h0, 0, 1, 32'h0000_0297, 32'h0000_0297, 3};
    vecs[1] = '{0, 32'h8000_0004, 0, 32'h0, 4'h0, 0, 3, 32'h0000_0413, 32'h0000_0413, 5};
    vecs[2] = '{1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 4, 1, 32'hCAFE_F00D, 32'h0, 7};
    vecs[3] = '{1, 32'h8000_1000, 0, 32'h0, 4'h0, 1, 2, 32'h0000_BEEF, 32'h0000_BEEF, 5};
    vecs[4] = '{0, 32'h8000_0008, 0, 32'h0, 4'h0, 2, 1, 32'hFE01_0113, 32'hFE01_0113, 5};
    vecs[5] = '{1, 32'h8000_1004, 1, 32'h0123_4567, 4'b1100, 0, 4, 32'hFFFF_FFFF, 32'h0, 6};
    vecs[6] = '{0, 32'h8000_0020, 0, 32'h0, 4'h0, 0, 1, 32'h0010_0093, 32'h0010_0093, 3};
    vecs[7] = '{1, 32'h8000_2000, 0, 32'h0, 4'h0, 0, 2, 32'hA0A0_A0A0, 32'hA0A0_A0A0, 4};

`ifdef ARB_ROUND_ROBIN_EN
    exp_tie = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_tie = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_rsp", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen}, 0);
    chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", {mem_wdata, 28'h0, mem_wmask}, 0);
    rst = 1'b1;

    run_vec(vecs[0], "ifu_first");

    // Both masters request continuously for four grants.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr      = 32'h0000_0100;
    lsu_addr      = 32'h0000_0200;
    lsu_wen       = 1'b0;
    lsu_wmask     = '0;
    rdy_dly       = 0;
    rsp_dly       = 1;
    mem_data      = 32'h5A5A_0001;
    exp_data      = mem_data;
    base          = grant_log.size();
    n             = 0;
    while (grant_log.size() < base + 4 && n < 100) begin
      step();
      n++;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    wait_pulse();
    chk("tie_count", grant_log.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < grant_log.size()) chk($sformatf("tie_grant%0d", i), grant_log[base+i], exp_tie[i]);
    end

    for (int i = 1; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the fetch is waiting on memory; the late response must be dropped.
    rdy_dly       = 0;
    rsp_dly       = 5;
    mem_data      = 32'hBAD0_0001;
    exp_data      = mem_data;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    wait_acc(n);
    ifu_req_valid = 1'b0;
    n = 0;
    while (!(exp_req_q.size() == 0 && rsp_cnt > 0) && n < 20) begin
      step();
      n++;
    end
    rst     = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
    rsp_cnt = 0;
    due     = 0;
    busy    = 0;
    step();
    rst  = 1'b1;
    spur = 1;
    repeat (3) step();
    run_vec(vecs[6], "post_rst");

    // Spurious response while idle must not surface or pollute the next read.
    spur = 1;
    repeat (2) step();
    run_vec(vecs[7], "post_spur");
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter sharing a single unified memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the RV32 core. It sits between the core's fetch/data paths and the memory model. It serialises one transaction at a time with valid/ready request handshakes and a variable-latency response, so the core can move from separate instruction/data memories to one shared port.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte mask width is `DATA_W/8`
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  one clock; reset is synchronous and active-low (`rst`==0 resets on the clock edge)
- `ifu_req_valid`  in  1  fetch request
- `ifu_req_ready`  out  1  fetch request accepted this cycle
- `ifu_addr`  in  ADDR_W  fetch address (pc)
- `ifu_rsp_valid`  out  1  one-cycle pulse, `ifu_rdata` valid
- `ifu_rdata`  out  DATA_W  instruction word
- `lsu_req_valid`  in  1  data request
- `lsu_req_ready`  out  1  data request accepted this cycle
- `lsu_addr`  in  ADDR_W  data address (ALU result)
- `lsu_wen`  in  1  1 = store, 0 = load
- `lsu_wdata`  in  DATA_W  store data (rs2)
- `lsu_wmask`  in  DATA_W/8  byte enables for stores
- `lsu_rsp_valid`  out  1  one-cycle pulse; load data valid or store done
- `lsu_rdata`  out  DATA_W  load data (0 for stores)
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  request fields
- `mem_rsp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_W  response data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any `*_req_valid` is high, grant exactly one master.
  - Assert that master's `*_req_ready` combinationally in the same cycle.
  - Latch the request fields and the owner id. Go to REQ.
  - IFU requests latch `wen`=0 and `wmask`=0.
- REQ: drive `mem_req_valid`=1 with the latched fields. On `mem_req_ready`=1, go to WAIT. Fields stay stable until accepted.
- WAIT: on `mem_rsp_valid`=1, register `mem_rdata` and go to RESP.
- RESP: pulse the owner's `*_rsp_valid` for one cycle with the registered data. The non-owner's `rsp_valid` stays 0. Go to IDLE.
- `*_req_ready` is 0 in every state except IDLE. Only one transaction is outstanding at a time.
- `mem_rsp_valid` in IDLE, REQ or RESP is ignored and dropped.
- Tie rule (both valid in IDLE): see Configuration.

## Timing
- Reset values: all outputs 0, state IDLE, rdata register 0, last-grant register = IFU.
- Reset mid-transaction: abort to IDLE. No response is delivered to either master. Any late `mem_rsp_valid` is dropped.
- Minimum latency, with memory ready and responding immediately:
  - cycle 0: accept
  - cycle 1: REQ
  - cycle 2: WAIT, sees response
  - cycle 3: RESP pulse
  - cycle 4: IDLE, next accept
- General case: accept at cycle 0, memory accepts at cycle a ≥ 1, memory responds at cycle r > a. Owner `rsp_valid` is at r+1, and the next accept is possible at r+2.
- Back-to-back requests from the same master are served in order. Requests are never reordered within a master.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, grant the master not granted last. The last-grant register updates on every grant. With reset value IFU, the first tie goes to LSU.
- Undefined: fixed priority. LSU always wins ties. The last-grant register is not built.

## Structure
- Package `arb_pkg`:
  - state enum `arb_state_t` {IDLE, REQ, WAIT, RESP}
  - master id constants `ARB_IFU`=0, `ARB_LSU`=1
- One sub-module, `arb_grant`: combinational tie-break that takes both valids plus last-grant and returns the grant id. It contains the `ARB_ROUND_ROBIN_EN` logic.
- The top holds the FSM, request latches and response register.

## Test plan
- Reset, `rst`=0 for 2 cycles → all outputs 0. The first IFU request to 0x80000000 gives `ifu_req_ready` at cycle 0 and `mem_req_valid` with `mem_addr`=0x80000000 at cycle 1.
- IFU fetch, memory responds 0x00000413 three cycles after accepting at r → `ifu_rsp_valid`=1 with `ifu_rdata`=0x00000413 at r+1 only; `lsu_rsp_valid` stays 0.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011 → `mem_wen`=1 and the same fields, held stable while `mem_req_ready`=0 for 4 cycles. Then `lsu_rsp_valid` pulses with `lsu_rdata`=0.
- Both valid every cycle for 4 grants → without the macro, all 4 grants go to LSU. With `ARB_ROUND_ROBIN_EN`, the order is LSU, IFU, LSU, IFU.
- `rst`=0 during WAIT, then `mem_rsp_valid`=1 after reset releases → no `*_rsp_valid`, state IDLE, the next request is served normally.
- Spurious `mem_rsp_valid`=1 in IDLE with `mem_rdata`=0x12345678 → no response pulse, and the next transaction returns its own data.
